index_sequencer: RTL

//  Initiator that walks an index from 0 to NUM_ITEMS-1 and hands it to a downstream consumer
//  (weight/input fetch, MAC) over a valid/ready handshake, then reports completion.
//  It drives its counter through clear/increment-style control and owns the "last" detection.
//  It sits between the layer controller (start/done) and the per-neuron datapath.

---
 rtl/index_sequencer_if.sv | 13 +
 rtl/index_sequencer.sv | 79 +++++++
 2 files changed

// File: rtl/index_sequencer_if.sv
// Index handshake between the sequencer (master) and the per-neuron datapath (slave).
interface index_sequencer_if #(
    parameter int IDX_W = 2
);
    logic [IDX_W-1:0] index;
    logic             valid;
    logic             ready;
    logic             first;
    logic             last;

    modport master (output index, output valid, output first, output last, input ready);
    modport slave  (input index, input valid, input first, input last, output ready);
endinterface

// File: rtl/index_sequencer.sv
// Walks index 0..NUM_ITEMS-1 over a valid/ready handshake, then pulses done for one cycle.
module index_sequencer #(
    parameter int NUM_ITEMS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       abort,
    index_sequencer_if.master          bus,
    output logic                       busy,
    output logic                       done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             valid;

    assign bus.index = index;
    assign bus.valid = valid;
    // first/last are decoded straight from the registered index so they line up with it
    assign bus.first = valid && (index == '0);
    assign bus.last  = valid && (index == LAST_IDX);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            index <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ISSUE;
                        index <= '0;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // abort wins over a handshake landing in the same cycle
                    if (abort) begin
                        state <= IDLE;
                        index <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (valid && bus.ready) begin
                        if (index == LAST_IDX) begin
                            state <= DONE;
                            index <= '0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    index <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
